// File: rtl/rs_pipe_rx_pkg.sv
// rs_pipe_pkg -- shared constants and sizing helpers for the rs_pipe_rx
// receive block.
//
// Contents:
//   PIPE_STAGES_MAX : largest supported number of link register stages per direction
//   SKID_MARGIN     : slack words on top of the round-trip flight
//   skid_words()    : words that can still arrive after rdy_up drops
//   ptr_width()     : FIFO pointer width for a given depth
//   occ_width()     : occupancy counter width (must also represent "full")
//   is_pow2()       : depth legality helper
package rs_pipe_pkg;

    localparam int PIPE_STAGES_MAX = 8;
    localparam int SKID_MARGIN     = 2;

    // Words that can still land after rdy_up is deasserted. This covers the
    // forward and backward link flight plus the two local register hops.
    function automatic int skid_words(input int pipeStages);
        return 2 * pipeStages + SKID_MARGIN;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that the value FIFO_DEPTH itself is representable.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/rs_pipe_rx_if.sv
// rs_pipe_rx_if -- link-side and kernel-side stream signals of rs_pipe_rx.
//
// Signals:
//   din, din_vld    : payload and valid arriving from the forward link pipeline
//   rdy_up          : credit returned into the backward link pipeline
//   dout, dout_vld  : registered first-word-fall-through output to the kernel
//   dout_rdy        : kernel accepts dout this cycle
//
// Modports:
//   slave  : the receive block (rs_pipe_rx)
//   master : the environment (link sender plus downstream kernel)
interface rs_pipe_rx_if #(
    parameter int PAYLOAD_BITS = 32
);

    logic [PAYLOAD_BITS-1:0] din;
    logic                    din_vld;
    logic                    rdy_up;
    logic [PAYLOAD_BITS-1:0] dout;
    logic                    dout_vld;
    logic                    dout_rdy;

    modport slave (
        input  din,
        input  din_vld,
        input  dout_rdy,
        output rdy_up,
        output dout,
        output dout_vld
    );

    modport master (
        output din,
        output din_vld,
        output dout_rdy,
        input  rdy_up,
        input  dout,
        input  dout_vld
    );

endinterface

// File: rtl/rs_pipe_rx_fifo.sv
// rs_pipe_rx_fifo -- plain dual-pointer storage for rs_pipe_rx.
//
// The owner decides when writing and reading are legal. This module only
// stores words and advances its pointers; it applies no flow-control policy.
// Pointers wrap naturally because FIFO_DEPTH is a power of two.
//
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset (clears pointers only)
//   wrEn_i    : write wrData_i at the write pointer and advance it
//   wrData_i  : word to store
//   rdEn_i    : advance the read pointer (the word was consumed)
//   rdData_o  : word at the read pointer (combinational read)
module rs_pipe_rx_fifo
    import rs_pipe_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wrEn_i,
    input  logic [PAYLOAD_BITS-1:0] wrData_i,
    input  logic                    rdEn_i,
    output logic [PAYLOAD_BITS-1:0] rdData_o
);

    localparam int PTR_W = ptr_width(FIFO_DEPTH);

    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wrPtr_q;
    logic [PTR_W-1:0]        rdPtr_q;

    // Pointers restart at slot zero on reset, so anything left in the array
    // becomes unreachable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (wrEn_i) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (rdEn_i) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
        end
    end

    // The storage array itself needs no reset.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdPtr_q];

endmodule

// File: rtl/rs_pipe_rx.sv
// rs_pipe_rx -- receive end of a pipelined stream link.
//
// Words arrive PIPE_STAGES registers after the sender launched them, with no
// handshake. The credit returns through another PIPE_STAGES registers. A
// local FIFO absorbs every word still in flight when rdy_up drops. Toward
// the kernel the block provides a registered first-word-fall-through
// valid/ready stream.
//
// Parameters:
//   PAYLOAD_BITS : data width (the interface instance must use the same width)
//   PIPE_STAGES  : link register stages per direction, 0..8
//   FIFO_DEPTH   : total words held, including the output register; a power
//                  of two and >= skid_words(PIPE_STAGES) + 2
//
// Ports:
//   ap_clk     : clock, rising edge
//   ap_rst     : asynchronous active-high reset
//   link       : rs_pipe_rx_if.slave (din/din_vld/rdy_up/dout/dout_vld/dout_rdy)
//   occupancy  : words held, including the output register
//   ovf        : sticky overflow flag (present only with RS_PIPE_RX_OVF_CHECK_EN)
//
// Optional build macro RS_PIPE_RX_OVF_CHECK_EN adds the ovf port and a
// simulation assertion on dropped pushes. Without it, a push into a full
// block that has no simultaneous pop is discarded silently.
module rs_pipe_rx
    import rs_pipe_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32,
    parameter int PIPE_STAGES  = 2,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    rs_pipe_rx_if.slave                      link,
    output logic [occ_width(FIFO_DEPTH)-1:0] occupancy
`ifdef RS_PIPE_RX_OVF_CHECK_EN
    , output logic                           ovf
`endif
);

    localparam int SKID  = skid_words(PIPE_STAGES);
    localparam int OCC_W = occ_width(FIFO_DEPTH);

    localparam logic [OCC_W-1:0] FULL_LEVEL = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] RDY_LIMIT  = OCC_W'(FIFO_DEPTH - SKID);

    // Parameter legality is enforced at elaboration time.
    if (PIPE_STAGES < 0 || PIPE_STAGES > PIPE_STAGES_MAX) begin : g_badStages
        $error("rs_pipe_rx: PIPE_STAGES must be within 0..%0d", PIPE_STAGES_MAX);
    end
    if (!is_pow2(FIFO_DEPTH)) begin : g_badDepthPow2
        $error("rs_pipe_rx: FIFO_DEPTH must be a power of two");
    end
    if (FIFO_DEPTH < SKID + 2) begin : g_badDepthSkid
        $error("rs_pipe_rx: FIFO_DEPTH must be at least %0d", SKID + 2);
    end

    logic [PAYLOAD_BITS-1:0] dout_q,    dout_d;
    logic                    doutVld_q, doutVld_d;
    logic [OCC_W-1:0]        occ_q,     occ_d;
    logic                    rdyUp_q,   rdyUp_d;

    logic                    pop;
    logic                    full;
    logic                    pushAcc;
    logic                    memEmpty;
    logic                    load;
    logic [PAYLOAD_BITS-1:0] fifoRdData;

    // Storage for words that have not yet moved into the output register.
    rs_pipe_rx_fifo #(
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (ap_clk),
        .rst_i    (ap_rst),
        .wrEn_i   (pushAcc),
        .wrData_i (link.din),
        .rdEn_i   (load),
        .rdData_o (fifoRdData)
    );

    // Flow control and next-state logic. occ_q counts the array contents plus
    // the output register. The array is therefore empty exactly when occ_q
    // equals doutVld_q. The output register reloads from the array whenever
    // it is empty or is being emptied by a pop. That load is what produces the
    // one-cycle fall-through latency. A push while full is accepted only when
    // a pop frees a slot on the same edge.
    always_comb begin
        pop       = doutVld_q && link.dout_rdy;
        full      = (occ_q == FULL_LEVEL);
        pushAcc   = link.din_vld && (!full || pop);
        memEmpty  = (occ_q == OCC_W'(doutVld_q));
        load      = !memEmpty && (!doutVld_q || pop);

        occ_d     = occ_q + OCC_W'(pushAcc) - OCC_W'(pop);
        dout_d    = load ? fifoRdData : dout_q;
        doutVld_d = load || (doutVld_q && !pop);
        rdyUp_d   = (occ_d <= RDY_LIMIT);
    end

    // Output register, occupancy counter and credit register. rdy_up is
    // computed from the next occupancy. When it falls, the FIFO still has at
    // least SKID free slots for the words already in flight.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            dout_q    <= '0;
            doutVld_q <= 1'b0;
            occ_q     <= '0;
            rdyUp_q   <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            doutVld_q <= doutVld_d;
            occ_q     <= occ_d;
            rdyUp_q   <= rdyUp_d;
        end
    end

    assign link.dout     = dout_q;
    assign link.dout_vld = doutVld_q;
    assign link.rdy_up   = rdyUp_q;
    assign occupancy     = occ_q;

`ifdef RS_PIPE_RX_OVF_CHECK_EN
    logic pushDrop;
    logic ovf_q;

    assign pushDrop = link.din_vld && !pushAcc;

    // Sticky record of any dropped push. A drop means the sender ignored the
    // credit protocol; only reset clears the flag.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ovf_q <= 1'b0;
        end else if (pushDrop) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;

    // Report the protocol violation on the edge where the word is lost.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst) begin
            assert (!pushDrop)
                else $error("rs_pipe_rx: push dropped while full (overflow)");
        end
    end
`endif

endmodule

// File: tb/tb_rs_pipe_rx.sv
// tb_rs_pipe_rx -- self-checking bench for rs_pipe_rx with the default
// configuration (PAYLOAD_BITS=32, PIPE_STAGES=2, FIFO_DEPTH=16).
//
// The bench applies a table of single-cycle vectors first. Hand-written
// sequences then cover credit-based streaming through modelled link
// pipelines, full-FIFO push/pop, overflow drop and asynchronous reset.
// When RS_PIPE_RX_OVF_CHECK_EN is defined, the ovf port is connected and
// checked as well.
module tb_rs_pipe_rx;

    localparam int PAYLOAD_BITS = 32;
    localparam int PIPE_STAGES  = 2;
    localparam int FIFO_DEPTH   = 16;
    localparam int OCC_W        = $clog2(FIFO_DEPTH) + 1;
    localparam int RDY_LIMIT    = FIFO_DEPTH - (2 * PIPE_STAGES + 2);
    localparam int STREAM_TOTAL = 40;
    localparam int STREAM_STALL = 30;
    localparam int NUM_VECS     = 12;

    logic             ap_clk = 1'b0;
    logic             ap_rst = 1'b1;
    logic [OCC_W-1:0] occupancy;
`ifdef RS_PIPE_RX_OVF_CHECK_EN
    logic             ovf;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] expWords[$];

    typedef struct {
        logic        dinVld;
        logic [31:0] din;
        logic        doutRdy;
        logic        expVld;
        logic [31:0] expDout;
        int          expOcc;
        logic        expRdyUp;
    } vec_t;

    vec_t vecs [NUM_VECS];

    rs_pipe_rx_if #(.PAYLOAD_BITS(PAYLOAD_BITS)) link();

    rs_pipe_rx #(
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .PIPE_STAGES  (PIPE_STAGES),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .link      (link),
        .occupancy (occupancy)
`ifdef RS_PIPE_RX_OVF_CHECK_EN
        , .ovf     (ovf)
`endif
    );

    // Free-running clock with a 10 ns period.
    always #5 ap_clk = ~ap_clk;

    // Compare one observed value against its expected value and log any miss.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the active edge.
    task automatic applyStimulus(input logic vld, input logic [31:0] data, input logic rdy);
        link.din_vld  = vld;
        link.din      = data;
        link.dout_rdy = rdy;
        @(posedge ap_clk);
        #1;
    endtask

    // Push FIFO_DEPTH consecutive words while the kernel stalls.
    task automatic fillFifo(input logic [31:0] base);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            applyStimulus(1'b1, base + 32'(i), 1'b0);
        end
    endtask

    // Keep dout_rdy high and compare each presented word with expWords.
    task automatic drainExpect(input string name, input int count, input int maxCycles);
        int got = 0;
        link.din_vld  = 1'b0;
        link.dout_rdy = 1'b1;
        for (int c = 0; c < maxCycles; c++) begin
            if (link.dout_vld) begin
                checkOutput($sformatf("%s word%0d", name, got), link.dout, expWords[got]);
                got++;
            end
            if (got == count) break;
            @(posedge ap_clk);
            #1;
        end
        checkOutput($sformatf("%s count", name), got, count);
    endtask

    // Sender honouring rdy_up through PIPE_STAGES backward registers. Its
    // words travel through PIPE_STAGES forward registers. The kernel stalls
    // at first and then drains. Occupancy is tracked as pushes minus pops.
    task automatic streamTest();
        logic        fv0 = 1'b0, fv1 = 1'b0;
        logic [31:0] fd0 = '0,   fd1 = '0;
        logic        b0 = 1'b0,  b1 = 1'b0;
        logic        rdyPrev;
        logic        launch;
        logic        pushedPrev = 1'b0;
        logic        poppedPrev = 1'b0;
        int          sent = 0;
        int          nextExp = 0;
        int          occModel = 0;
        int          maxOcc = 0;
        bit          sawLow = 1'b0;

        rdyPrev       = link.rdy_up;
        link.din_vld  = 1'b0;
        link.din      = '0;
        link.dout_rdy = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge ap_clk);
            #1;
            occModel = occModel + int'(pushedPrev) - int'(poppedPrev);
            if (occModel > maxOcc) maxOcc = occModel;
            if (occModel > RDY_LIMIT) sawLow = 1'b1;
            checkOutput("stream occupancy", occupancy, occModel);
            checkOutput("stream rdy_up", link.rdy_up, occModel <= RDY_LIMIT);
            if (nextExp == STREAM_TOTAL && occModel == 0) break;

            link.dout_rdy = (cyc >= STREAM_STALL);
            poppedPrev    = link.dout_vld && link.dout_rdy;
            if (poppedPrev) begin
                checkOutput("stream order", link.dout, nextExp);
                nextExp++;
            end

            launch = b1 && (sent < STREAM_TOTAL);
            fv1 = fv0;
            fd1 = fd0;
            fv0 = launch;
            fd0 = launch ? 32'(sent) : 32'h0;
            if (launch) sent++;
            b1      = b0;
            b0      = rdyPrev;
            rdyPrev = link.rdy_up;

            link.din_vld = fv1;
            link.din     = fd1;
            pushedPrev   = fv1;
        end
        checkOutput("stream words received", nextExp, STREAM_TOTAL);
        checkOutput("stream rdy_up fell", sawLow, 1'b1);
        checkOutput("stream peak within depth", maxOcc <= FIFO_DEPTH, 1'b1);
    endtask

    initial begin
        // Vector table: {dinVld, din, doutRdy, expVld, expDout, expOcc, expRdyUp}
        vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        0, 1'b1};
        vecs[1]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1, 1'b1};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 0, 1'b1};
        vecs[4]  = '{1'b1, 32'h1,        1'b0, 1'b0, 32'hDEADBEEF, 1, 1'b1};
        vecs[5]  = '{1'b1, 32'h2,        1'b0, 1'b1, 32'h1,        2, 1'b1};
        vecs[6]  = '{1'b1, 32'h3,        1'b0, 1'b1, 32'h1,        3, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h2,        2, 1'b1};
        vecs[8]  = '{1'b1, 32'h4,        1'b1, 1'b1, 32'h3,        2, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        1, 1'b1};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h4,        0, 1'b1};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h4,        0, 1'b1};

        link.din_vld  = 1'b0;
        link.din      = '0;
        link.dout_rdy = 1'b0;

        // Reset state
        repeat (2) @(posedge ap_clk);
        #1;
        checkOutput("reset rdy_up", link.rdy_up, 1'b0);
        checkOutput("reset dout_vld", link.dout_vld, 1'b0);
        checkOutput("reset dout", link.dout, 32'h0);
        checkOutput("reset occupancy", occupancy, 0);
        ap_rst = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].dinVld, vecs[i].din, vecs[i].doutRdy);
            checkOutput($sformatf("vec%0d dout_vld", i), link.dout_vld, vecs[i].expVld);
            checkOutput($sformatf("vec%0d dout", i), link.dout, vecs[i].expDout);
            checkOutput($sformatf("vec%0d occupancy", i), occupancy, vecs[i].expOcc);
            checkOutput($sformatf("vec%0d rdy_up", i), link.rdy_up, vecs[i].expRdyUp);
        end

        // Credit-based streaming through the link model
        streamTest();

        // Full FIFO with simultaneous push and pop
        fillFifo(32'h100);
        checkOutput("full occupancy", occupancy, FIFO_DEPTH);
        checkOutput("full dout_vld", link.dout_vld, 1'b1);
        checkOutput("full dout head", link.dout, 32'h100);
        checkOutput("full rdy_up", link.rdy_up, 1'b0);
        applyStimulus(1'b1, 32'hA5, 1'b1);
        checkOutput("push+pop occupancy", occupancy, FIFO_DEPTH);
        checkOutput("push+pop dout", link.dout, 32'h101);
        expWords.delete();
        for (int i = 1; i < FIFO_DEPTH; i++) expWords.push_back(32'h100 + 32'(i));
        expWords.push_back(32'hA5);
        drainExpect("push+pop drain", FIFO_DEPTH, 40);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("push+pop empty occupancy", occupancy, 0);
        checkOutput("push+pop empty dout_vld", link.dout_vld, 1'b0);

        // Full FIFO, push without pop is dropped
        fillFifo(32'h200);
        applyStimulus(1'b1, 32'h55, 1'b0);
        checkOutput("drop occupancy", occupancy, FIFO_DEPTH);
        checkOutput("drop dout held", link.dout, 32'h200);
        checkOutput("drop dout_vld held", link.dout_vld, 1'b1);
`ifdef RS_PIPE_RX_OVF_CHECK_EN
        checkOutput("drop ovf set", ovf, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("drop ovf sticky", ovf, 1'b1);
`endif
        expWords.delete();
        for (int i = 0; i < FIFO_DEPTH; i++) expWords.push_back(32'h200 + 32'(i));
        drainExpect("drop drain", FIFO_DEPTH, 40);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("drop empty occupancy", occupancy, 0);
        checkOutput("drop empty dout_vld", link.dout_vld, 1'b0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0);
        ap_rst = 1'b1;
        #2;
        checkOutput("async reset rdy_up", link.rdy_up, 1'b0);
        checkOutput("async reset dout_vld", link.dout_vld, 1'b0);
        checkOutput("async reset dout", link.dout, 32'h0);
        checkOutput("async reset occupancy", occupancy, 0);
`ifdef RS_PIPE_RX_OVF_CHECK_EN
        checkOutput("async reset ovf", ovf, 1'b0);
`endif
        link.din_vld = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("post-reset rdy_up", link.rdy_up, 1'b1);
        applyStimulus(1'b1, 32'hCAFE0001, 1'b1);
        checkOutput("post-reset occupancy", occupancy, 1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("post-reset dout_vld", link.dout_vld, 1'b1);
        checkOutput("post-reset dout", link.dout, 32'hCAFE0001);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/rs_pipe_rx.md
Name: rs_pipe_rx

Overview:
- Receive end of a pipelined stream link built from chains of registered stages.
- Data/valid arrive from the sender after PIPE_STAGES register delays; a ready indication returns to the sender through another PIPE_STAGES register delays.
- The block absorbs all in-flight words in a local FIFO so none are lost to round-trip latency.
- Presents a standard valid/ready stream to the downstream kernel.

Parameters:
- PAYLOAD_BITS, 32, data width in bits.
- PIPE_STAGES, 2, register stages in each direction of the link (forward data, backward ready); legal range 0..8.
- FIFO_DEPTH, 16, FIFO entries; power of 2; must be >= SKID+2, with SKID = 2*PIPE_STAGES+2 (elaboration error otherwise).

Ports:
- ap_clk  input  1  clock; all logic on rising edge.
- ap_rst  input  1  asynchronous, active-high reset.
- din  input  PAYLOAD_BITS  payload arriving from link pipeline.
- din_vld  input  1  word valid this cycle; no handshake, a valid word must be taken.
- rdy_up  output  1  credit/ready sent back into the backward link pipeline.
- dout  output  PAYLOAD_BITS  payload to downstream.
- dout_vld  output  1  dout holds a valid word.
- dout_rdy  input  1  downstream accepts; transfer when dout_vld && dout_rdy.
- occupancy  output  clog2(FIFO_DEPTH)+1  words held, including the output register.

Behaviour:
- Reset (async assert; released synchronously by the environment): rdy_up=0, dout_vld=0, dout=0, occupancy=0, pointers=0.
- push = din_vld; pop = dout_vld && dout_rdy.
- occupancy next = occupancy + push_accepted - pop.
- Push and pop in the same cycle leave occupancy unchanged.
- Latency: a word sampled at edge E0 into an empty block shows dout_vld=1 after edge E1 (1 cycle).
- Ordering is strict FIFO. dout is registered, first-word-fall-through.
- dout and dout_vld hold stable while dout_vld && !dout_rdy.
- rdy_up is registered: rdy_up next = (occupancy_next <= FIFO_DEPTH - SKID).
  - First edge after reset release drives rdy_up=1.
  - Guarantees room for every word launched before the sender observes rdy_up=0.
- Full (occupancy==FIFO_DEPTH):
  - push with simultaneous pop is accepted.
  - push without pop is dropped and storage is unchanged; this is an overflow.
  - Overflow is a sender protocol violation.
- Empty: dout_vld=0 and dout holds its last value; dout_rdy is ignored.
- Pointers are clog2(FIFO_DEPTH) bits and wrap naturally modulo FIFO_DEPTH.
- Reset asserted mid-transfer discards all contents immediately; rdy_up drops asynchronously to 0.

Optional Feature:
- Macro: RS_PIPE_RX_OVF_CHECK_EN.
- Defined:
  - Adds output port ovf (1 bit): sticky, set on the edge where a push is dropped, cleared only by ap_rst.
  - Adds a simulation assertion that fires on overflow.
- Undefined:
  - No ovf port, no assertion.
  - A dropped push is silently discarded; all other behaviour is identical.

Decomposition:
- Package rs_pipe_pkg:
  - function skid_words(PIPE_STAGES) = 2*PIPE_STAGES+2;
  - localparam helpers for pointer and occupancy widths (clog2);
  - PIPE_STAGES upper-limit constant.
- Sub-module rs_pipe_rx_fifo:
  - dual-pointer storage array with write port and read port;
  - no flow-control policy.
- rs_pipe_rx holds:
  - output register stage;
  - occupancy counter;
  - rdy_up generation;
  - overflow logic.

Test Plan:
1. Reset then idle (PIPE_STAGES=2, FIFO_DEPTH=16) -> rdy_up=1 one edge after release; dout_vld=0; occupancy=0.
2. Single word 0xDEADBEEF, dout_rdy=1 -> dout_vld=1 with dout=0xDEADBEEF exactly 1 cycle later; occupancy returns to 0 next cycle.
3. Streaming with dout_rdy=0, sender model honouring rdy_up through 2 backward stages and 2 forward stages -> rdy_up falls when occupancy exceeds 10; occupancy peaks <= 16; no drop.
4. Then dout_rdy=1 -> all words emerge in order 0,1,2,... with no gaps once rdy_up returns.
5. Full FIFO (16 words) with simultaneous push 0xA5 and pop -> push accepted, occupancy stays 16, 0xA5 appears last.
6. Full FIFO, push 0x55 without pop -> word dropped, occupancy 16. With RS_PIPE_RX_OVF_CHECK_EN, ovf=1 after that edge and stays 1 until ap_rst. Assert ap_rst mid-stream -> all outputs 0 immediately, no clock edge needed.
